// File: rtl/clk_seq_pkg.sv
// Shared types for the clock-wizard reset sequencer: state encodings and debug width.
package clk_seq_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single slow status bit, synchronous reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/clk_wiz_reset_seq.sv
// Sequences the MMCM reset, waits for a stable lock with timeout/retry, then
// releases the downstream reset. Runs from a free-running clock.
module clk_wiz_reset_seq
    import clk_seq_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT    = 65536,
    parameter int unsigned STABLE_CYCLES   = 1024,
    parameter int unsigned MAX_RETRIES     = 3,
    localparam int unsigned RC_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mmcm_locked,
    input  logic               restart,
    output logic               mmcm_reset,
    output logic               rst_out,
    output logic               ready,
    output logic               fail,
    output logic [RC_W-1:0]    retry_count,
    output logic [STATE_W-1:0] state_dbg
);

    localparam int unsigned CNT_MAX = max3(RST_HOLD_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RC_W-1:0]  RETRY_MAX   = RC_W'(MAX_RETRIES);

    logic locked_s;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (mmcm_locked),
        .q     (locked_s)
    );

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RC_W-1:0]   retry_q, retry_d;
    logic              mmcm_reset_q, mmcm_reset_d;
    logic              rst_out_q, rst_out_d;
    logic              ready_q, ready_d;
    logic              fail_q, fail_d;

    // Next state, shared counter, retry tracking and Moore outputs decoded from next state.
    always_comb begin
        state_d      = state_q;
        retry_d      = retry_q;
        cnt_d        = cnt_q;
        mmcm_reset_d = 1'b1;
        rst_out_d    = 1'b1;
        ready_d      = 1'b0;
        fail_d       = 1'b0;

        if (restart) begin
            state_d = ST_HOLD;
            retry_d = '0;
        end else begin
            unique case (state_q)
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = ST_STABLE;
                    end else if (cnt_q == LOCK_LAST) begin
                        if (retry_q == RETRY_MAX) begin
                            state_d = ST_FAIL;
                        end else begin
                            retry_d = retry_q + RC_W'(1);
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_STABLE: begin
                    if (!locked_s) begin
                        if (retry_q == RETRY_MAX) begin
                            state_d = ST_FAIL;
                        end else begin
                            retry_d = retry_q + RC_W'(1);
                            state_d = ST_HOLD;
                        end
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!locked_s) state_d = ST_HOLD;
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_HOLD;
                end
            endcase
        end

        if (state_d == ST_RUN && state_q != ST_RUN) retry_d = '0;

        // Counter only matters in the timed states; it idles in RUN and FAIL.
        if (restart || state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == ST_HOLD || state_q == ST_WAIT_LOCK || state_q == ST_STABLE) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        unique case (state_d)
            ST_WAIT_LOCK, ST_STABLE: mmcm_reset_d = 1'b0;
            ST_RUN: begin
                mmcm_reset_d = 1'b0;
                rst_out_d    = 1'b0;
                ready_d      = 1'b1;
            end
            ST_FAIL: fail_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_HOLD;
            cnt_q        <= '0;
            retry_q      <= '0;
            mmcm_reset_q <= 1'b1;
            rst_out_q    <= 1'b1;
            ready_q      <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            mmcm_reset_q <= mmcm_reset_d;
            rst_out_q    <= rst_out_d;
            ready_q      <= ready_d;
            fail_q       <= fail_d;
        end
    end

    assign mmcm_reset  = mmcm_reset_q;
    assign rst_out     = rst_out_q;
    assign ready       = ready_q;
    assign fail        = fail_q;
    assign retry_count = retry_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_clk_wiz_reset_seq.sv
// Bench for clk_wiz_reset_seq: directed timing scenarios plus randomized lock/restart/reset
// traffic, every cycle compared against a behavioural model of the sequencing rules.
module tb_clk_wiz_reset_seq;

    localparam int unsigned P_HOLD   = 4;
    localparam int unsigned P_TO     = 32;
    localparam int unsigned P_STABLE = 8;
    localparam int unsigned P_MAXR   = 2;

    localparam int S_HOLD = 0, S_WAIT = 1, S_STABLE = 2, S_RUN = 3, S_FAIL = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mmcm_locked = 1'b0;
    logic       restart = 1'b0;
    logic       mmcm_reset, rst_out, ready, fail;
    logic [1:0] retry_count;
    logic [2:0] state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    // Model: phase, time spent in phase, failed attempts, and the two-cycle view delay of locked.
    int m_st = S_HOLD, m_time = 0, m_retry = 0;
    bit m_seen1 = 0, m_seen2 = 0;

    clk_wiz_reset_seq #(
        .RST_HOLD_CYCLES (P_HOLD),
        .LOCK_TIMEOUT    (P_TO),
        .STABLE_CYCLES   (P_STABLE),
        .MAX_RETRIES     (P_MAXR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mmcm_locked (mmcm_locked),
        .restart     (restart),
        .mmcm_reset  (mmcm_reset),
        .rst_out     (rst_out),
        .ready       (ready),
        .fail        (fail),
        .retry_count (retry_count),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic fail_attempt(output int nxt);
        if (m_retry == P_MAXR) nxt = S_FAIL;
        else begin
            m_retry++;
            nxt = S_HOLD;
        end
    endtask

    task automatic model_step(input bit rst, input bit rs, input bit lk);
        int  nxt;
        bit  view;
        if (rst) begin
            m_st = S_HOLD; m_time = 0; m_retry = 0; m_seen1 = 0; m_seen2 = 0;
            return;
        end
        view    = m_seen2;
        m_seen2 = m_seen1;
        m_seen1 = lk;
        nxt     = m_st;
        if (rs) begin
            nxt = S_HOLD;
            m_retry = 0;
        end else if (m_st == S_HOLD) begin
            if (m_time + 1 >= P_HOLD) nxt = S_WAIT;
        end else if (m_st == S_WAIT) begin
            if (view) nxt = S_STABLE;
            else if (m_time + 1 >= P_TO) fail_attempt(nxt);
        end else if (m_st == S_STABLE) begin
            if (!view) fail_attempt(nxt);
            else if (m_time + 1 >= P_STABLE) nxt = S_RUN;
        end else if (m_st == S_RUN) begin
            if (!view) nxt = S_HOLD;
        end
        if (nxt == S_RUN && m_st != S_RUN) m_retry = 0;
        m_time = (rs || nxt != m_st) ? 0 : m_time + 1;
        m_st   = nxt;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(reset, restart, mmcm_locked);
        #1;
        check("state", 32'(state_dbg), 32'(m_st));
        check("mmcm_reset", 32'(mmcm_reset), 32'(m_st == S_HOLD || m_st == S_FAIL));
        check("rst_out", 32'(rst_out), 32'(m_st != S_RUN));
        check("ready", 32'(ready), 32'(m_st == S_RUN));
        check("fail", 32'(fail), 32'(m_st == S_FAIL));
        check("retry", 32'(retry_count), 32'(m_retry));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(state_dbg), 0);
        check({tag, "_mmcm_reset"}, 32'(mmcm_reset), 1);
        check({tag, "_rst_out"}, 32'(rst_out), 1);
        check({tag, "_ready"}, 32'(ready), 0);
        check({tag, "_fail"}, 32'(fail), 0);
        check({tag, "_retry"}, 32'(retry_count), 0);
    endtask

    task automatic count_hold(input string tag);
        int n = 0;
        while (mmcm_reset === 1'b1 && n < 200) begin tick(); n++; end
        check(tag, n, P_HOLD);
    endtask

    task automatic wait_state(input string tag, input int st);
        int n = 0;
        while (state_dbg !== 3'(st) && n < 200) begin tick(); n++; end
        check(tag, 32'(n < 200), 1);
    endtask

    initial begin
        int n;
        bit saw_release;

        // Reset state
        repeat (3) tick();
        check_reset_values("reset");

        // Normal bring-up, lock 10 cycles after reset release
        reset = 1'b0;
        count_hold("bringup_hold_len");
        repeat (10 - P_HOLD) tick();
        mmcm_locked = 1'b1;
        wait_state("bringup_to_stable", S_STABLE);
        n = 0;
        while (ready !== 1'b1 && n < 200) begin tick(); n++; end
        check("bringup_stable_len", n, P_STABLE);
        check("bringup_rst_out", 32'(rst_out), 0);
        check("bringup_retry", 32'(retry_count), 0);

        // Lock loss in RUN
        mmcm_locked = 1'b0;
        n = 0;
        while (ready === 1'b1 && n < 50) begin tick(); n++; end
        check("loss_latency", n, 3);
        check("loss_rst_out", 32'(rst_out), 1);
        check("loss_state", 32'(state_dbg), S_HOLD);
        check("loss_retry", 32'(retry_count), 0);
        repeat (20 - 3) tick();
        mmcm_locked = 1'b1;
        wait_state("relock_run", S_RUN);

        // Lock drop at STABLE cycle 5
        restart = 1'b1; tick(); restart = 1'b0;
        wait_state("drop_to_stable", S_STABLE);
        repeat (5) tick();
        mmcm_locked = 1'b0;
        saw_release = 0;
        n = 0;
        while (state_dbg !== 3'(S_HOLD) && n < 50) begin
            tick(); n++;
            if (rst_out === 1'b0) saw_release = 1;
        end
        check("drop_state", 32'(state_dbg), S_HOLD);
        check("drop_retry", 32'(retry_count), 1);
        check("drop_no_release", 32'(saw_release), 0);

        // Timeout and retry to FAIL
        restart = 1'b1; tick(); restart = 1'b0;
        for (int k = 0; k <= int'(P_MAXR); k++) begin
            count_hold($sformatf("to_hold_len%0d", k));
            n = 0;
            while (state_dbg === 3'(S_WAIT) && n < 200) begin tick(); n++; end
            check($sformatf("to_wait_len%0d", k), n, P_TO);
            if (k < int'(P_MAXR)) begin
                check($sformatf("to_retry%0d", k), 32'(retry_count), 32'(k + 1));
            end else begin
                check("to_fail", 32'(fail), 1);
                check("to_fail_mmcm_reset", 32'(mmcm_reset), 1);
                check("to_fail_retry", 32'(retry_count), P_MAXR);
            end
        end
        repeat (5) tick();
        check("fail_terminal", 32'(fail), 1);

        // restart from FAIL
        restart = 1'b1; tick(); restart = 1'b0;
        check("rs_fail_state", 32'(state_dbg), S_HOLD);
        check("rs_fail_retry", 32'(retry_count), 0);
        check("rs_fail_fail", 32'(fail), 0);

        // restart on the WAIT_LOCK timeout edge
        count_hold("rs_to_hold_len");
        repeat (P_TO - 1) tick();
        restart = 1'b1; tick(); restart = 1'b0;
        check("rs_to_state", 32'(state_dbg), S_HOLD);
        check("rs_to_retry", 32'(retry_count), 0);
        check("rs_to_fail", 32'(fail), 0);

        // Reset mid-STABLE
        mmcm_locked = 1'b1;
        wait_state("rst_mid_to_stable", S_STABLE);
        repeat (3) tick();
        reset = 1'b1; tick();
        check_reset_values("rst_mid");
        reset = 1'b0;
        count_hold("rst_mid_hold_len");

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = int'($urandom_range(0, 999));
            reset   = (r < 2);
            restart = (r >= 2 && r < 7);
            if ($urandom_range(0, 39) == 0) mmcm_locked = ~mmcm_locked;
            tick();
        end
        reset = 1'b0;
        restart = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
